// File: rtl/pim_job_sequencer.sv
// Job sequencer for the PIM CFU: loads a burst of weight rows, then runs bit-serial MAC
// commands and returns the captured accumulator value on a result stream.
module pim_job_sequencer #(
    parameter int unsigned AWIDTH   = 10,
    parameter int unsigned DWIDTH   = 32,
    parameter int unsigned MAC_TAIL = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        cfg_base,
    input  logic [8:0]        cfg_len,
    input  logic [5:0]        cfg_steps,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_data,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [AWIDTH-1:0] cmd_payload_function_id,
    output logic [DWIDTH-1:0] cmd_payload_inputs_0,
    output logic [DWIDTH-1:0] cmd_payload_inputs_1,
    input  logic              rsp_valid,
    output logic              rsp_ready,
    input  logic [DWIDTH-1:0] rsp_payload_outputs_0,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DWIDTH-1:0] res_data,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CW = $clog2(32 + MAC_TAIL + 1);
    localparam logic [AWIDTH-1:0] MacFid = {{(AWIDTH - 2){1'b0}}, 2'b10};

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StMac,
        StCapt,
        StResult,
        StFinish
    } state_e;

    state_e          state_q;
    logic [7:0]      base_q;
    logic [8:0]      len_q;
    logic [5:0]      steps_q;
    logic [8:0]      idx_q;
    logic [CW-1:0]   mac_cnt_q;
    logic [CW-1:0]   mac_total;
    logic [7:0]      row;
    logic            rsp_valid_unused;

    // Responses are drained blindly; only the CAPT sample carries information.
    assign rsp_valid_unused     = rsp_valid;
    assign mac_total            = CW'(steps_q) + CW'(MAC_TAIL);
    assign row                  = base_q + idx_q[7:0];
    assign in_ready             = (state_q == StLoad) && !cmd_valid && (idx_q < len_q);
    assign busy                 = (state_q != StIdle);
    assign cmd_payload_inputs_1 = '0;

    function automatic logic [AWIDTH-1:0] load_fid(input logic [7:0] r);
        logic [AWIDTH-1:0] f;
        f = '0;
        f[AWIDTH-1 -: 8] = r;
        f[1:0] = 2'b01;
        return f;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q                 <= StIdle;
            base_q                  <= '0;
            len_q                   <= '0;
            steps_q                 <= '0;
            idx_q                   <= '0;
            mac_cnt_q               <= '0;
            cmd_valid               <= 1'b0;
            cmd_payload_function_id <= '0;
            cmd_payload_inputs_0    <= '0;
            rsp_ready               <= 1'b0;
            res_valid               <= 1'b0;
            res_data                <= '0;
            done                    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        base_q    <= cfg_base;
                        len_q     <= cfg_len;
                        steps_q   <= cfg_steps;
                        idx_q     <= '0;
                        mac_cnt_q <= '0;
                        if (cfg_len != 9'd0) begin
                            state_q   <= StLoad;
                            rsp_ready <= 1'b1;
                        end else if (cfg_steps != 6'd0) begin
                            state_q   <= StMac;
                            rsp_ready <= 1'b1;
                        end else begin
                            state_q <= StFinish;
                        end
                    end
                end
                StLoad: begin
                    if (in_valid && in_ready) begin
                        cmd_payload_inputs_0    <= in_data;
                        cmd_payload_function_id <= load_fid(row);
                        cmd_valid               <= 1'b1;
                    end else if (cmd_valid && cmd_ready) begin
                        cmd_valid <= 1'b0;
                        idx_q     <= idx_q + 9'd1;
                        if (idx_q + 9'd1 == len_q) begin
                            if (steps_q != 6'd0) begin
                                state_q <= StMac;
                            end else begin
                                state_q   <= StFinish;
                                rsp_ready <= 1'b0;
                                done      <= 1'b1;
                            end
                        end
                    end
                end
                StMac: begin
                    // First MAC cycle only raises cmd_valid; handshakes follow back to back.
                    if (!cmd_valid) begin
                        cmd_valid               <= 1'b1;
                        cmd_payload_function_id <= MacFid;
                        cmd_payload_inputs_0    <= '0;
                    end else if (cmd_ready) begin
                        mac_cnt_q <= mac_cnt_q + 1'b1;
                        if (mac_cnt_q + 1'b1 == mac_total) begin
                            cmd_valid <= 1'b0;
                            state_q   <= StCapt;
                        end
                    end
                end
                StCapt: begin
                    res_data  <= rsp_payload_outputs_0;
                    res_valid <= 1'b1;
                    rsp_ready <= 1'b0;
                    state_q   <= StResult;
                end
                StResult: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        done      <= 1'b1;
                        state_q   <= StFinish;
                    end
                end
                StFinish: begin
                    // Paths that arrive with done already high end the pulse; the empty job
                    // raises done here so it lands two cycles after start.
                    done    <= !done;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_pim_job_sequencer.sv
// Directed bench for pim_job_sequencer: load bursts, address wrap, backpressure, MAC/result,
// zero-length job, ignored start and asynchronous reset mid-job.
module tb_pim_job_sequencer;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [7:0]    cfg_base;
    logic [8:0]    cfg_len;
    logic [5:0]    cfg_steps;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_payload_function_id;
    logic [DW-1:0] cmd_payload_inputs_0;
    logic [DW-1:0] cmd_payload_inputs_1;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_payload_outputs_0;
    logic          res_valid;
    logic          res_ready;
    logic [DW-1:0] res_data;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    pim_job_sequencer #(.AWIDTH(AW), .DWIDTH(DW), .MAC_TAIL(3)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .start                   (start),
        .cfg_base                (cfg_base),
        .cfg_len                 (cfg_len),
        .cfg_steps               (cfg_steps),
        .in_valid                (in_valid),
        .in_ready                (in_ready),
        .in_data                 (in_data),
        .cmd_valid               (cmd_valid),
        .cmd_ready               (cmd_ready),
        .cmd_payload_function_id (cmd_payload_function_id),
        .cmd_payload_inputs_0    (cmd_payload_inputs_0),
        .cmd_payload_inputs_1    (cmd_payload_inputs_1),
        .rsp_valid               (rsp_valid),
        .rsp_ready               (rsp_ready),
        .rsp_payload_outputs_0   (rsp_payload_outputs_0),
        .res_valid               (res_valid),
        .res_ready               (res_ready),
        .res_data                (res_data),
        .busy                    (busy),
        .done                    (done)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] words [8];
    int          feed_n = 0;
    int          feed_ptr = 0;
    bit          feed_fire = 1'b0;
    logic [AW-1:0] fid_q [$];
    logic [31:0] dat_q [$];
    logic [31:0] in1_q [$];
    int          done_cnt = 0;
    int          mac_seen = 0;
    int          mac_base = 0;
    int          mac_expect = 1000;
    logic [31:0] rsp_word = 32'h0;

    // CFU model: the accumulator value only appears once the expected MAC count has issued.
    assign rsp_valid             = 1'b1;
    assign rsp_payload_outputs_0 = (mac_seen - mac_base == mac_expect) ? rsp_word : 32'h1234_5678;

    always @(posedge clk) begin
        if (cmd_valid && cmd_ready) begin
            fid_q.push_back(cmd_payload_function_id);
            dat_q.push_back(cmd_payload_inputs_0);
            in1_q.push_back(cmd_payload_inputs_1);
            if (cmd_payload_function_id == 10'h002) mac_seen++;
        end
        if (done) done_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (feed_fire) feed_ptr++;
        in_valid  = (feed_ptr < feed_n);
        in_data   = in_valid ? words[feed_ptr] : '0;
        feed_fire = in_valid && in_ready;
    endtask

    task automatic feed(input int n);
        feed_ptr  = 0;
        feed_n    = n;
        feed_fire = 1'b0;
    endtask

    task automatic start_job(input logic [7:0] b, input logic [8:0] l, input logic [5:0] s);
        cfg_base  = b;
        cfg_len   = l;
        cfg_steps = s;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check_eq({tag, " idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int cb;
        int db;
        int n;
        int bad;
        logic [AW-1:0] f0;
        logic [31:0]   d0;

        reset = 1'b1;  start = 1'b0;  cfg_base = '0;  cfg_len = '0;  cfg_steps = '0;
        in_valid = 1'b0;  in_data = '0;  cmd_ready = 1'b1;  res_ready = 1'b0;
        tick();
        tick();
        check_eq("rst cmd_valid", 32'(cmd_valid), 0);
        check_eq("rst in_ready", 32'(in_ready), 0);
        check_eq("rst rsp_ready", 32'(rsp_ready), 0);
        check_eq("rst res_valid", 32'(res_valid), 0);
        check_eq("rst busy", 32'(busy), 0);
        check_eq("rst done", 32'(done), 0);
        check_eq("rst fid", 32'(cmd_payload_function_id), 0);
        check_eq("rst res_data", res_data, 0);
        reset = 1'b0;
        tick();

        // Load burst, base 0x10
        words[0] = 32'hA000_000A;  words[1] = 32'hB000_000B;  words[2] = 32'hC000_000C;
        cb = fid_q.size();  db = done_cnt;
        feed(3);
        start_job(8'h10, 9'd3, 6'd0);
        wait_idle("burst", 40);
        tick();
        check_eq("burst count", fid_q.size() - cb, 3);
        check_eq("burst fid0", 32'(fid_q[cb]), 32'h041);
        check_eq("burst fid1", 32'(fid_q[cb + 1]), 32'h045);
        check_eq("burst fid2", 32'(fid_q[cb + 2]), 32'h049);
        check_eq("burst dat0", dat_q[cb], 32'hA000_000A);
        check_eq("burst dat1", dat_q[cb + 1], 32'hB000_000B);
        check_eq("burst dat2", dat_q[cb + 2], 32'hC000_000C);
        check_eq("burst in1", in1_q[cb] | in1_q[cb + 1] | in1_q[cb + 2], 0);
        check_eq("burst done", done_cnt - db, 1);

        // Address wrap
        cb = fid_q.size();
        feed(2);
        start_job(8'hFF, 9'd2, 6'd0);
        wait_idle("wrap", 40);
        check_eq("wrap count", fid_q.size() - cb, 2);
        check_eq("wrap fid0", 32'(fid_q[cb]), 32'h3FD);
        check_eq("wrap fid1", 32'(fid_q[cb + 1]), 32'h001);

        // Backpressure mid-LOAD
        words[0] = 32'h1111_0001;  words[1] = 32'h2222_0002;  words[2] = 32'h3333_0003;
        cb = fid_q.size();
        cmd_ready = 1'b0;
        feed(3);
        start_job(8'h20, 9'd3, 6'd0);
        n = 0;
        while (!cmd_valid && n < 10) begin
            tick();
            n++;
        end
        check_eq("bp cmd_valid", 32'(cmd_valid), 1);
        f0 = cmd_payload_function_id;
        d0 = cmd_payload_inputs_0;
        check_eq("bp first fid", 32'(f0), 32'h081);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("bp fid stable", 32'(cmd_payload_function_id), 32'(f0));
            check_eq("bp data stable", cmd_payload_inputs_0, 32'h1111_0001);
            check_eq("bp in_ready", 32'(in_ready), 0);
        end
        check_eq("bp consumed", feed_ptr, 1);
        cmd_ready = 1'b1;
        wait_idle("bp", 40);
        tick();
        check_eq("bp count", fid_q.size() - cb, 3);
        check_eq("bp fid2", 32'(fid_q[cb + 2]), 32'h089);
        check_eq("bp dat1", dat_q[cb + 1], 32'h2222_0002);
        check_eq("bp dat2", dat_q[cb + 2], 32'h3333_0003);
        check_eq("bp consumed all", feed_ptr, 3);

        // MAC and result under res backpressure
        cb = fid_q.size();  db = done_cnt;
        mac_base = mac_seen;  mac_expect = 7;  rsp_word = 32'hDEAD_BEEF;
        feed(0);
        start_job(8'h00, 9'd0, 6'd4);
        n = 0;
        while (!res_valid && n < 40) begin
            tick();
            n++;
        end
        check_eq("mac res_valid", 32'(res_valid), 1);
        check_eq("mac count", fid_q.size() - cb, 7);
        bad = 0;
        for (int i = cb; i < fid_q.size(); i++)
            if (fid_q[i] != 10'h002 || dat_q[i] != 32'h0) bad++;
        check_eq("mac payloads", bad, 0);
        check_eq("mac res_data", res_data, 32'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("res hold valid", 32'(res_valid), 1);
            check_eq("res hold data", res_data, 32'hDEAD_BEEF);
        end
        check_eq("res no early done", done_cnt - db, 0);
        res_ready = 1'b1;
        tick();
        check_eq("res done pulse", 32'(done), 1);
        res_ready = 1'b0;
        tick();
        tick();
        check_eq("res done count", done_cnt - db, 1);
        check_eq("res busy", 32'(busy), 0);

        // Minimum job timing: res_valid at cycle 9 after start
        mac_base = mac_seen;  mac_expect = 4;  rsp_word = 32'hCAFE_0001;
        words[0] = 32'h5555_AAAA;
        feed(1);
        start_job(8'h00, 9'd1, 6'd1);
        n = 1;
        while (!res_valid && n < 20) begin
            tick();
            n++;
        end
        check_eq("min res cycle", n, 9);
        check_eq("min res_data", res_data, 32'hCAFE_0001);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        wait_idle("min", 10);

        // Empty job: done two cycles after start
        db = done_cnt;
        start_job(8'h00, 9'd0, 6'd0);
        check_eq("empty done c1", 32'(done), 0);
        check_eq("empty busy c1", 32'(busy), 1);
        tick();
        check_eq("empty done c2", 32'(done), 1);
        check_eq("empty busy c2", 32'(busy), 0);
        tick();
        check_eq("empty done count", done_cnt - db, 1);

        // Second start while busy is ignored
        words[0] = 32'h0000_0C01;  words[1] = 32'h0000_0C02;
        cb = fid_q.size();  db = done_cnt;
        feed(2);
        start_job(8'h30, 9'd2, 6'd0);
        start_job(8'h80, 9'd1, 6'd5);
        wait_idle("ign", 40);
        tick();
        tick();
        check_eq("ign count", fid_q.size() - cb, 2);
        check_eq("ign fid0", 32'(fid_q[cb]), 32'h0C1);
        check_eq("ign fid1", 32'(fid_q[cb + 1]), 32'h0C5);
        check_eq("ign done", done_cnt - db, 1);

        // Asynchronous reset mid-LOAD
        cmd_ready = 1'b0;
        feed(4);
        start_job(8'h40, 9'd4, 6'd0);
        n = 0;
        while (!cmd_valid && n < 10) begin
            tick();
            n++;
        end
        check_eq("rstmid cmd_valid pre", 32'(cmd_valid), 1);
        db = done_cnt;
        #2 reset = 1'b1;
        #1;
        check_eq("rstmid cmd_valid", 32'(cmd_valid), 0);
        check_eq("rstmid busy", 32'(busy), 0);
        check_eq("rstmid in_ready", 32'(in_ready), 0);
        check_eq("rstmid rsp_ready", 32'(rsp_ready), 0);
        feed(0);
        tick();
        tick();
        reset = 1'b0;
        cmd_ready = 1'b1;
        tick();
        tick();
        tick();
        check_eq("rstmid no done", done_cnt - db, 0);

        // Normal job after reset
        words[0] = 32'h7777_0007;
        cb = fid_q.size();  db = done_cnt;
        mac_base = mac_seen;  mac_expect = 4;  rsp_word = 32'h0BAD_F00D;
        feed(1);
        res_ready = 1'b1;
        start_job(8'h50, 9'd1, 6'd1);
        wait_idle("post", 60);
        tick();
        check_eq("post count", fid_q.size() - cb, 5);
        check_eq("post fid0", 32'(fid_q[cb]), 32'h141);
        check_eq("post dat0", dat_q[cb], 32'h7777_0007);
        check_eq("post res_data", res_data, 32'h0BAD_F00D);
        check_eq("post done", done_cnt - db, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pim_job_sequencer.md
# pim_job_sequencer

Upstream command sequencer for the PIM CFU. It takes a job descriptor and a weight-word stream, then drives the CFU `cmd_*`/`rsp_*` port: a burst of row writes, then a run of bit-serial MAC commands. It captures the MAC result from the CFU response data and presents it on a result stream, so software or a DMA can run a full load-and-MAC job with one `start` pulse.

## Interface
- `AWIDTH`, 10: CFU function_id width (must be at least 10).
  - Bits [AWIDTH-1:AWIDTH-8] carry the row address; bits [1:0] carry {p_en, w_en}; all other bits are 0.
- `DWIDTH`, 32: data width of the weight stream, CFU payload and result.
- `MAC_TAIL`, 3: extra MAC commands issued after `cfg_steps` to flush the CFU accumulate/output pipeline.
- `clk`  in  1: single clock; all logic is on the rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state and outputs.
- `start`  in  1: one-cycle job request; honoured only in IDLE.
- `cfg_base`  in  8: first PIM row address for the load burst.
- `cfg_len`  in  9: rows to load, 0..256; 0 skips LOAD.
- `cfg_steps`  in  6: MAC steps, 0..32; 0 skips MAC/CAPT/RESULT.
- `in_valid` in 1, `in_ready` out 1, `in_data` in DWIDTH: weight stream.
- `cmd_valid` out 1, `cmd_ready` in 1: CFU command handshake.
- `cmd_payload_function_id` out AWIDTH, `cmd_payload_inputs_0` out DWIDTH: CFU command payload.
- `cmd_payload_inputs_1` out DWIDTH: CFU command payload, tied to 0.
- `rsp_valid` in 1, `rsp_ready` out 1, `rsp_payload_outputs_0` in DWIDTH: CFU response.
- `res_valid` out 1, `res_ready` in 1, `res_data` out DWIDTH: result stream.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at job end.

## Operation
- **Reset values.** All outputs are 0, including `cmd_valid`, `in_ready`, `rsp_ready`, `res_valid`, `busy`, `done` and all payloads. State is IDLE and counters are 0.
- **IDLE.** On `start`, latch `cfg_*`. Next state is:
  - LOAD if `cfg_len` ≠ 0;
  - else MAC if `cfg_steps` ≠ 0;
  - else FINISH.
- **Ignored starts.** `start` outside IDLE is ignored. Descriptor changes after the latch are ignored.
- **LOAD.**
  - `in_ready` = (state==LOAD) && !`cmd_valid` && (rows sent < len).
  - On an `in` handshake, register `in_data` into `cmd_payload_inputs_0` and set function_id = {row, 2'b01}, where row = (base+idx) mod 256. Assert `cmd_valid`.
  - On a `cmd` handshake, drop `cmd_valid` next cycle and increment idx.
  - After the len-th handshake, go to MAC, or to FINISH if steps = 0.
- **MAC.**
  - Hold `cmd_valid` high with function_id = {8'h00, 2'b10} and `inputs_0` = 0.
  - Count handshakes; one command can issue per cycle.
  - After `cfg_steps`+`MAC_TAIL` handshakes, drop `cmd_valid` and go to CAPT.
- **CAPT.** One cycle. Sample `rsp_payload_outputs_0` into `res_data` and go to RESULT.
- **RESULT.** `res_valid` is high; `res_data` is stable. On a `res` handshake, go to FINISH.
- **FINISH.** Pulse `done` for 1 cycle and return to IDLE.
- **`rsp_ready`.** Registered. High in LOAD, MAC and CAPT; low otherwise. It never depends combinationally on `cmd_ready` or `rsp_valid`, so there is no loop with the CFU's ready pass-through.
  - Response beats are accepted and discarded. The only data used is the CAPT sample.
- **Payload stability.** While `cmd_valid` is high and `cmd_ready` is low, function_id and `inputs_0` are held stable.
- **Address wrap.** Row address wraps modulo 256 (base 0xFF, idx 1 → row 0x00).
- **Reset mid-job.** Asserting `reset` mid-job drops `cmd_valid`/`res_valid` immediately (async) and returns to IDLE with no `done` pulse. Partially loaded PIM rows are not rolled back.

## Timing
- **LOAD throughput.** One row per 2 cycles at best: the `in` handshake at cycle t gives `cmd_valid` at t+1. With `cmd_ready`=1, the next `in_ready` is at t+2.
- **MAC rate.** With `cmd_ready`=1, MAC commands issue back to back, one per cycle.
- **Capture point.** CAPT is the first cycle after the final MAC handshake. `res_valid` rises the cycle after CAPT.
- **`done`.** Asserted the cycle after the `res` handshake, or 2 cycles after `start` when len = steps = 0.
- **Minimum job** (len=1, steps=1, MAC_TAIL=3, all ready tied high): `start` at cycle 0 gives `res_valid` at cycle 9.

## Test plan
- **Reset.** Assert `reset` async mid-cycle → all outputs 0 before the next edge; `busy`=0.
- **Load burst.** base=0x10, len=3, words A,B,C, `cmd_ready`=1 → function_ids 0x041, 0x045, 0x049 carrying A, B, C in order; `inputs_1`=0.
- **Wrap.** base=0xFF, len=2 → function_ids 0x3FD then 0x001.
- **Backpressure.** Hold `cmd_ready`=0 for 5 cycles mid-LOAD → function_id and `inputs_0` are stable, `in_ready`=0, and no word is consumed or dropped.
- **MAC and result.**
  - Setup: len=0, steps=4, CFU model drives 0xDEADBEEF in CAPT, `res_ready` held low for 3 cycles.
  - Required: exactly 7 commands with function_id 0x002, then `res_data`=0xDEADBEEF held stable under `res_ready`=0, then a single `done` pulse.
- **Ignored start and reset mid-LOAD.**
  - A second `start` while `busy` → no effect.
  - `reset` during LOAD → `cmd_valid` drops at once, no `done`; a new job then runs normally.
